io_intr_unit: RTL and testbench
===============================

Name: io_intr_unit

Overview:
- Downstream consumer of the instruction decoder's I/O and interrupt strobes: rFI, rFO, sFO, ION and IOF.
- Owns these registers:
  - FGI: input flag.
  - FGO: output flag.
  - IEN: interrupt enable.
  - INPR: input buffer.
  - OUTR: output buffer.
- Runs valid/ready handshakes to an external input device and an external output device.
- Generates the interrupt request and the interrupt-take sequence that the PC/fetch logic consumes at instruction boundaries.

Parameters:
- DATA_W, 8, width of INPR, OUTR and the device data buses.
- PC_W, 12, program-counter width.
- INT_VEC, 12'h001, PC value loaded when an interrupt is taken.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- opcode  in  5  current instruction opcode; IN = 5'b11000, OUT = 5'b11001.
- instr_done  in  1  one-cycle strobe at the last cycle of each instruction; all strobes below are qualified by it.
- rFI, rFO, sFO, ION, IOF  in  1 each  decoder outputs.
- acc_data  in  DATA_W  register data sourced by OUT.
- in_data  out  DATA_W  INPR contents, written back by IN.
- fgi, fgo, ien  out  1 each  flag state (readable by jz-style tests).
- dev_in_valid  in  1  input device offers a byte.
- dev_in_data  in  DATA_W  input byte.
- dev_in_ready  out  1  asserted when FGI = 0.
- dev_out_valid  out  1  OUTR holds a byte for the device.
- dev_out_data  out  DATA_W  OUTR contents.
- dev_out_ready  in  1  output device accepts.
- irq_take  out  1  one-cycle pulse: fetch must save PC and load int_pc.
- int_pc  out  PC_W  constant INT_VEC.

Behaviour:
- Reset (sync, while reset = 1):
  - FGI = 0, FGO = 1, IEN = 0.
  - INPR = 0, OUTR = 0.
  - dev_out_valid = 0, irq_take = 0.
  - Output FSM = O_IDLE, interrupt FSM = I_IDLE.
  - Reset mid-transfer drops the byte with no device handshake.
- Input channel:
  - dev_in_ready = !FGI (combinational).
  - On dev_in_valid & dev_in_ready: INPR <= dev_in_data and FGI <= 1 at the next edge.
  - rFI & instr_done: FGI <= 0.
  - Device set and rFI in the same cycle: set wins.
  - IN instruction only reads in_data; it does not clear FGI. Software issues resetFI.
- Output channel FSM:
  - O_IDLE: dev_out_valid = 0. On opcode == OUT & instr_done: OUTR <= acc_data, FGO <= 0, next state O_BUSY.
  - O_BUSY: dev_out_valid = 1, dev_out_data = OUTR. On dev_out_ready: FGO <= 1, next state O_IDLE.
  - OUT issued while in O_BUSY is ignored: OUTR is unchanged and the byte is lost; software must test FGO first.
  - rFO & instr_done: FGO <= 0. sFO & instr_done: FGO <= 1. Neither changes the FSM state.
  - Device completion and rFO in the same cycle: completion wins (FGO = 1).
- Interrupt enable:
  - ION & instr_done: IEN <= 1. IOF & instr_done: IEN <= 0. Both asserted: IOF wins.
  - IEN change is visible from the next cycle.
- Interrupt FSM:
  - req = IEN & (FGI | FGO) (combinational on registered flags).
  - I_IDLE: if req, next state I_PEND.
  - I_PEND: if !req, return to I_IDLE. If instr_done & req: irq_take = 1 for exactly that cycle, IEN <= 0, next state I_IDLE.
  - An IOF retiring in the same cycle suppresses the take (IOF priority).
  - Latency: earliest irq_take is the first instr_done at least one cycle after req rises. Minimum is 2 cycles from the FGI set edge.
- All flag updates are registered. No combinational path from dev_out_ready to dev_out_valid.

Decomposition:
- Shared package cpu_pkg: opcode constants OP_IN, OP_OUT, OP_RFI, OP_SFO, OP_RFO, OP_ION, OP_IOF, OP_HLT. The decoder uses the same constants.
- One natural sub-module: io_out_chan (OUTR + O_IDLE/O_BUSY FSM + FGO logic). The input flag and interrupt FSM remain in the top.

Test Plan:
- Reset check: after reset → fgi = 0, fgo = 1, ien = 0, dev_in_ready = 1, dev_out_valid = 0, irq_take = 0.
- Input path: device drives 8'hA5 with valid for 1 cycle → next cycle fgi = 1, in_data = A5, dev_in_ready = 0. A second offer of 8'h3C is not accepted. rFI + instr_done → fgi = 0; then 3C is accepted.
- Output path: OUT with acc_data = 8'h5A + instr_done → next cycle dev_out_valid = 1, data = 5A, fgo = 0. Hold dev_out_ready low 3 cycles → valid stays. Ready high 1 cycle → fgo = 1, valid = 0.
- Interrupt: ION retire, then device writes 8'h11. Next instr_done → irq_take pulse of 1 cycle, int_pc = 12'h001, ien = 0 afterwards; no second pulse.
- Priority: ION + IOF in one instr_done → ien = 0. Device completion + rFO same cycle → fgo = 1. rFI coincident with a device write while FGI = 0 → fgi = 1.
- Reset mid-operation: assert reset during O_BUSY with IEN = 1 and FGI = 1 → next cycle all reset values; no irq_take.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings common to the decoder and the
// I/O-interrupt unit, plus the state encodings of the I/O unit's two FSMs.
package cpu_pkg;

  localparam logic [4:0] OP_IN  = 5'b11000;
  localparam logic [4:0] OP_OUT = 5'b11001;
  localparam logic [4:0] OP_RFI = 5'b11010;
  localparam logic [4:0] OP_SFO = 5'b11011;
  localparam logic [4:0] OP_RFO = 5'b11100;
  localparam logic [4:0] OP_ION = 5'b11101;
  localparam logic [4:0] OP_IOF = 5'b11110;
  localparam logic [4:0] OP_HLT = 5'b11111;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_BUSY = 1'b1
  } out_state_e;

  typedef enum logic {
    I_IDLE = 1'b0,
    I_PEND = 1'b1
  } int_state_e;

  // True when the retiring instruction carries the given opcode.
  function automatic logic op_retires(input logic [4:0] opc,
                                      input logic [4:0] which,
                                      input logic       done);
    return done && (opc == which);
  endfunction

endpackage

// File: rtl/io_out_chan.sv
// Output channel: OUTR buffer, FGO flag and the O_IDLE/O_BUSY handshake FSM
// towards the external output device.
module io_out_chan
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              out_cmd,
  input  logic [DATA_W-1:0] acc_data,
  input  logic              rfo_cmd,
  input  logic              sfo_cmd,
  input  logic              dev_out_ready,
  output logic              dev_out_valid,
  output logic [DATA_W-1:0] dev_out_data,
  output logic              fgo
);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic              fgo_q, fgo_d;

  // State, buffer and flag registers; reset drops any byte in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= O_IDLE;
      outr_q  <= '0;
      fgo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      outr_q  <= outr_d;
      fgo_q   <= fgo_d;
    end
  end

  // Next-state logic: software flag writes first, FSM events override them
  // so that a device completion beats a coincident rFO.
  always_comb begin
    state_d = state_q;
    outr_d  = outr_q;
    fgo_d   = fgo_q;
    if (rfo_cmd) fgo_d = 1'b0;
    if (sfo_cmd) fgo_d = 1'b1;
    case (state_q)
      O_IDLE: begin
        if (out_cmd) begin
          outr_d  = acc_data;
          fgo_d   = 1'b0;
          state_d = O_BUSY;
        end
      end
      O_BUSY: begin
        // An OUT issued here is dropped; software is expected to poll FGO.
        if (dev_out_ready) begin
          fgo_d   = 1'b1;
          state_d = O_IDLE;
        end
      end
      default: state_d = O_IDLE;
    endcase
  end

  // Valid comes straight from the state register, never from ready.
  assign dev_out_valid = (state_q == O_BUSY);
  assign dev_out_data  = outr_q;
  assign fgo           = fgo_q;

endmodule

// File: rtl/io_intr_unit.sv
// I/O and interrupt unit: input flag/buffer, interrupt enable, interrupt
// request/take FSM, and the output channel sub-module.
module io_intr_unit
  import cpu_pkg::*;
#(
  parameter int              DATA_W  = 8,
  parameter int              PC_W    = 12,
  parameter logic [PC_W-1:0] INT_VEC = 12'h001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        opcode,
  input  logic              instr_done,
  input  logic              rFI,
  input  logic              rFO,
  input  logic              sFO,
  input  logic              ION,
  input  logic              IOF,
  input  logic [DATA_W-1:0] acc_data,
  output logic [DATA_W-1:0] in_data,
  output logic              fgi,
  output logic              fgo,
  output logic              ien,
  input  logic              dev_in_valid,
  input  logic [DATA_W-1:0] dev_in_data,
  output logic              dev_in_ready,
  output logic              dev_out_valid,
  output logic [DATA_W-1:0] dev_out_data,
  input  logic              dev_out_ready,
  output logic              irq_take,
  output logic [PC_W-1:0]   int_pc
);

  logic              fgi_q;
  logic              ien_q;
  logic [DATA_W-1:0] inpr_q;
  logic              fgo_w;
  logic              in_accept;
  logic              req;
  logic              take;
  logic              iof_ret;
  int_state_e        ist_q, ist_d;

  assign iof_ret      = instr_done && IOF;
  assign in_accept    = dev_in_valid && !fgi_q;
  assign dev_in_ready = !fgi_q;

  // Input buffer and FGI: a device write sets the flag; rFI only clears it
  // when no write lands, which is implicit since writes need FGI = 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      fgi_q  <= 1'b0;
      inpr_q <= '0;
    end else if (in_accept) begin
      fgi_q  <= 1'b1;
      inpr_q <= dev_in_data;
    end else if (instr_done && rFI) begin
      fgi_q  <= 1'b0;
    end
  end

  // Interrupt enable: IOF beats everything, a take disables further
  // interrupts, ION sets it otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      ien_q <= 1'b0;
    end else if (iof_ret) begin
      ien_q <= 1'b0;
    end else if (take) begin
      ien_q <= 1'b0;
    end else if (instr_done && ION) begin
      ien_q <= 1'b1;
    end
  end

  assign req = ien_q && (fgi_q || fgo_w);

  // Interrupt FSM state register.
  always_ff @(posedge clk) begin
    if (reset) ist_q <= I_IDLE;
    else       ist_q <= ist_d;
  end

  // Interrupt FSM next state: a request must be seen for one cycle (I_PEND)
  // before an instruction boundary may take it.
  always_comb begin
    ist_d = ist_q;
    take  = 1'b0;
    case (ist_q)
      I_IDLE: begin
        if (req) ist_d = I_PEND;
      end
      I_PEND: begin
        if (!req) begin
          ist_d = I_IDLE;
        end else if (instr_done && !iof_ret && !reset) begin
          take  = 1'b1;
          ist_d = I_IDLE;
        end
      end
      default: ist_d = I_IDLE;
    endcase
  end

  io_out_chan #(
    .DATA_W(DATA_W)
  ) u_out_chan (
    .clk          (clk),
    .reset        (reset),
    .out_cmd      (op_retires(opcode, OP_OUT, instr_done)),
    .acc_data     (acc_data),
    .rfo_cmd      (instr_done && rFO),
    .sfo_cmd      (instr_done && sFO),
    .dev_out_ready(dev_out_ready),
    .dev_out_valid(dev_out_valid),
    .dev_out_data (dev_out_data),
    .fgo          (fgo_w)
  );

  assign in_data  = inpr_q;
  assign fgi      = fgi_q;
  assign fgo      = fgo_w;
  assign ien      = ien_q;
  assign irq_take = take;
  assign int_pc   = INT_VEC;

endmodule

// File: tb/tb_io_intr_unit.sv
// Directed table-driven bench for io_intr_unit.
module tb_io_intr_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] opcode;
  logic       instr_done, rFI, rFO, sFO, ION, IOF;
  logic [7:0] acc_data, in_data, dev_in_data, dev_out_data;
  logic       fgi, fgo, ien, dev_in_valid, dev_in_ready;
  logic       dev_out_valid, dev_out_ready, irq_take;
  logic [11:0] int_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_intr_unit #(.DATA_W(8), .PC_W(12), .INT_VEC(12'h001)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .instr_done(instr_done),
    .rFI(rFI), .rFO(rFO), .sFO(sFO), .ION(ION), .IOF(IOF),
    .acc_data(acc_data), .in_data(in_data), .fgi(fgi), .fgo(fgo), .ien(ien),
    .dev_in_valid(dev_in_valid), .dev_in_data(dev_in_data),
    .dev_in_ready(dev_in_ready), .dev_out_valid(dev_out_valid),
    .dev_out_data(dev_out_data), .dev_out_ready(dev_out_ready),
    .irq_take(irq_take), .int_pc(int_pc)
  );

  typedef struct {
    logic       rst;
    logic [4:0] opc;
    logic       done, rfi, rfo, sfo, ion, iof;
    logic [7:0] acc;
    logic       dv;
    logic [7:0] dd;
    logic       dr;
    logic       e_take, e_fgi, e_fgo, e_ien;
    logic [7:0] e_in;
    logic       e_ov;
    logic [7:0] e_od;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;

  task automatic add(input logic rst, input logic [4:0] opc, input logic done,
                     input logic rfi, input logic rfo, input logic sfo,
                     input logic ion, input logic iof, input logic [7:0] acc,
                     input logic dv, input logic [7:0] dd, input logic dr,
                     input logic e_take, input logic e_fgi, input logic e_fgo,
                     input logic e_ien, input logic [7:0] e_in,
                     input logic e_ov, input logic [7:0] e_od);
    vt[nv] = '{rst, opc, done, rfi, rfo, sfo, ion, iof, acc, dv, dd, dr,
               e_take, e_fgi, e_fgo, e_ien, e_in, e_ov, e_od};
    nv++;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; opcode = v.opc; instr_done = v.done;
    rFI = v.rfi; rFO = v.rfo; sFO = v.sfo; ION = v.ion; IOF = v.iof;
    acc_data = v.acc; dev_in_valid = v.dv; dev_in_data = v.dd;
    dev_out_ready = v.dr;
  endtask

  initial begin
    vec_t idle_v;
    int   pulses;
    int   first_at;
    localparam logic [4:0] NOP = 5'b00000;

    //   rst opc   dn rfi rfo sfo ion iof acc  dv dd  dr | tk fgi fgo ien in  ov od
    add(1, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h00, 0,8'h00); // 0 reset
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h00, 0,8'h00); // 1 idle
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 1,8'hA5,0,   0, 1,1,0, 8'hA5, 0,8'h00); // 2 accept A5
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 1,8'h3C,0,   0, 1,1,0, 8'hA5, 0,8'h00); // 3 3C refused
    add(0, NOP,    1, 1,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'hA5, 0,8'h00); // 4 rFI
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 1,8'h3C,0,   0, 1,1,0, 8'h3C, 0,8'h00); // 5 accept 3C
    add(0, NOP,    1, 1,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h3C, 0,8'h00); // 6 rFI
    add(0, OP_OUT, 1, 0,0,0,0,0, 8'h5A, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'h5A); // 7 OUT 5A
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'h5A); // 8 wait
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'h5A); // 9 wait
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'h5A); // 10 wait
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,1,   0, 0,1,0, 8'h3C, 0,8'h5A); // 11 ready
    add(0, OP_OUT, 1, 0,0,0,0,0, 8'hC3, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'hC3); // 12 OUT C3
    add(0, NOP,    1, 0,1,0,0,0, 8'h00, 0,8'h00,1,   0, 0,1,0, 8'h3C, 0,8'hC3); // 13 done+rFO
    add(0, OP_OUT, 1, 0,0,0,0,0, 8'h77, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'h77); // 14 OUT 77
    add(0, OP_OUT, 1, 0,0,0,0,0, 8'h88, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'h77); // 15 OUT lost
    add(0, NOP,    1, 0,0,1,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h3C, 1,8'h77); // 16 sFO busy
    add(0, NOP,    1, 0,1,0,0,0, 8'h00, 0,8'h00,0,   0, 0,0,0, 8'h3C, 1,8'h77); // 17 rFO busy
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,1,   0, 0,1,0, 8'h3C, 0,8'h77); // 18 ready
    add(0, NOP,    1, 0,0,0,1,1, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h3C, 0,8'h77); // 19 ION+IOF
    add(0, NOP,    1, 1,0,0,0,0, 8'h00, 1,8'h5E,0,   0, 1,1,0, 8'h5E, 0,8'h77); // 20 write+rFI
    add(0, NOP,    1, 1,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h5E, 0,8'h77); // 21 rFI
    add(0, NOP,    1, 0,1,0,0,0, 8'h00, 0,8'h00,0,   0, 0,0,0, 8'h5E, 0,8'h77); // 22 rFO idle
    add(0, NOP,    1, 0,0,0,1,0, 8'h00, 0,8'h00,0,   0, 0,0,1, 8'h5E, 0,8'h77); // 23 ION
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,0,1, 8'h5E, 0,8'h77); // 24 idle
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 1,8'h11,0,   0, 1,0,1, 8'h11, 0,8'h77); // 25 write 11
    add(0, NOP,    1, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 1,0,1, 8'h11, 0,8'h77); // 26 too early
    add(0, NOP,    1, 0,0,0,0,0, 8'h00, 0,8'h00,0,   1, 1,0,0, 8'h11, 0,8'h77); // 27 take
    add(0, NOP,    1, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 1,0,0, 8'h11, 0,8'h77); // 28 no repeat
    add(0, NOP,    1, 1,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,0,0, 8'h11, 0,8'h77); // 29 rFI
    add(0, NOP,    1, 0,0,0,1,0, 8'h00, 0,8'h00,0,   0, 0,0,1, 8'h11, 0,8'h77); // 30 ION
    add(0, NOP,    1, 0,0,1,0,0, 8'h00, 0,8'h00,0,   0, 0,1,1, 8'h11, 0,8'h77); // 31 sFO
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,1, 8'h11, 0,8'h77); // 32 pend
    add(0, NOP,    1, 0,0,0,0,1, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h11, 0,8'h77); // 33 IOF blocks
    add(0, NOP,    1, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h11, 0,8'h77); // 34 none
    add(0, OP_OUT, 1, 0,0,0,0,0, 8'h99, 0,8'h00,0,   0, 0,0,0, 8'h11, 1,8'h99); // 35 OUT 99
    add(0, NOP,    1, 0,0,0,1,0, 8'h00, 0,8'h00,0,   0, 0,0,1, 8'h11, 1,8'h99); // 36 ION
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 1,8'h42,0,   0, 1,0,1, 8'h42, 1,8'h99); // 37 write 42
    add(0, NOP,    0, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 1,0,1, 8'h42, 1,8'h99); // 38 pend
    add(1, NOP,    1, 0,0,0,0,0, 8'h00, 0,8'h00,0,   0, 0,1,0, 8'h00, 0,8'h00); // 39 reset
    add(0, NOP,    1, 0,0,0,0,0, 8'h00, 0,8'h00,1,   0, 0,1,0, 8'h00, 0,8'h00); // 40 after

    for (int i = 0; i < nv; i++) begin
      drive(vt[i]);
      @(negedge clk);
      chk("irq_take", i, 32'(irq_take), 32'(vt[i].e_take));
      @(posedge clk);
      #1;
      chk("fgi", i, 32'(fgi), 32'(vt[i].e_fgi));
      chk("fgo", i, 32'(fgo), 32'(vt[i].e_fgo));
      chk("ien", i, 32'(ien), 32'(vt[i].e_ien));
      chk("in_data", i, 32'(in_data), 32'(vt[i].e_in));
      chk("dev_in_ready", i, 32'(dev_in_ready), 32'(!vt[i].e_fgi));
      chk("dev_out_valid", i, 32'(dev_out_valid), 32'(vt[i].e_ov));
      chk("dev_out_data", i, 32'(dev_out_data), 32'(vt[i].e_od));
    end

    // Hand sequence: FGO = 1 here, so ION alone raises req; with instr_done
    // held high the take lands on the second boundary and fires only once.
    idle_v = vt[40];
    idle_v.dr = 1'b0;
    idle_v.ion = 1'b1;
    drive(idle_v);
    @(posedge clk);
    #1;
    idle_v.ion = 1'b0;
    drive(idle_v);
    pulses = 0;
    first_at = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (irq_take) begin
        pulses++;
        if (first_at < 0) first_at = c;
        chk("int_pc", 100 + c, 32'(int_pc), 32'h001);
      end
      @(posedge clk);
      #1;
    end
    chk("take_pulses", 100, 32'(pulses), 32'd1);
    chk("take_latency", 100, 32'(first_at), 32'd1);
    chk("ien_after_take", 100, 32'(ien), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
